// File: rtl/rst_seq_nexysvideo.sv
// Board reset sequencer for the Nexys Video top.
// Merges the reset button, JTAG system reset and PLL lock into one clean
// active-low system reset, with debounce, synchronisers and release stretch.
// Ports:
//   clk_i          free-running board clock
//   rst_i          synchronous active-high power-on reset
//   btn_rst_ni     raw reset pushbutton (async, active-low, bouncy)
//   srst_ni        JTAG system reset from padctl (async, active-low)
//   pll_locked_i   clkgen PLL/MMCM lock (async)
//   rst_sys_no     system reset to top_earlgrey, active-low
//   rst_active_o   high whenever the sequencer is not in RUN
//   reset_cause_o  00 POR, 01 button, 10 JTAG srst, 11 PLL lock loss
//   rst_count_o    saturating count of RUN->HOLD transitions
module rst_seq_nexysvideo #(
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 50000,
    parameter int unsigned StretchCycles  = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_rst_ni,
    input  logic       srst_ni,
    input  logic       pll_locked_i,
    output logic       rst_sys_no,
    output logic       rst_active_o,
    output logic [1:0] reset_cause_o,
    output logic [7:0] rst_count_o
);

    localparam int unsigned DbW = $clog2(DebounceCycles + 1);
    localparam int unsigned StW = $clog2(StretchCycles + 1);

    // RUN owns its own state bit so the released reset comes from one flop.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_STRETCH = 2'b01,
        ST_RUN     = 2'b10
    } state_e;

    logic [SyncStages-1:0] btn_sync, srst_sync, lock_sync;
    logic                  btn_s, srst_s, lock_s;
    logic                  btn_filt;
    logic [DbW-1:0]        db_cnt;
    logic                  req_btn, req_srst, req_lock, any_req;
    logic [1:0]            cause_sel;

    state_e         state_q, state_d;
    logic [StW-1:0] st_cnt_q, st_cnt_d;
    logic [1:0]     cause_q, cause_d;
    logic [7:0]     count_q, count_d;
    logic           active_q;

    // Input synchronisers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_sync  <= '1;
            srst_sync <= '1;
            lock_sync <= '0;
        end else begin
            btn_sync  <= {btn_sync[SyncStages-2:0], btn_rst_ni};
            srst_sync <= {srst_sync[SyncStages-2:0], srst_ni};
            lock_sync <= {lock_sync[SyncStages-2:0], pll_locked_i};
        end
    end

    assign btn_s  = btn_sync[SyncStages-1];
    assign srst_s = srst_sync[SyncStages-1];
    assign lock_s = lock_sync[SyncStages-1];

    // Button debounce: filtered value follows only after a full stable run
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_filt <= 1'b1;
            db_cnt   <= '0;
        end else if (btn_s != btn_filt) begin
            if (db_cnt == DbW'(DebounceCycles - 1)) begin
                btn_filt <= btn_s;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DbW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign req_btn  = ~btn_filt;
    assign req_srst = ~srst_s;
    assign req_lock = ~lock_s;
    assign any_req  = req_btn | req_srst | req_lock;

    // Cause priority: lock > button > srst
    always_comb begin
        if (req_lock)     cause_sel = 2'b11;
        else if (req_btn) cause_sel = 2'b01;
        else              cause_sel = 2'b10;
    end

    // State and bookkeeping registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_HOLD;
            st_cnt_q <= '0;
            cause_q  <= 2'b00;
            count_q  <= 8'd0;
            active_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            st_cnt_q <= st_cnt_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
            active_q <= (state_d != ST_RUN);
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        st_cnt_d = st_cnt_q;
        cause_d  = cause_q;
        count_d  = count_q;
        case (state_q)
            ST_HOLD: begin
                if (!any_req) begin
                    state_d  = ST_STRETCH;
                    st_cnt_d = '0;
                end
            end
            ST_STRETCH: begin
                if (any_req) begin
                    state_d = ST_HOLD;
                    cause_d = cause_sel;
                end else begin
                    st_cnt_d = st_cnt_q + StW'(1);
                    if (st_cnt_q == StW'(StretchCycles - 1)) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (any_req) begin
                    state_d = ST_HOLD;
                    cause_d = cause_sel;
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    assign rst_sys_no    = state_q[1];
    assign rst_active_o  = active_q;
    assign reset_cause_o = cause_q;
    assign rst_count_o   = count_q;

endmodule

// File: tb/tb_rst_seq_nexysvideo.sv
// Self-checking bench for rst_seq_nexysvideo (DebounceCycles reduced to 8).
module tb_rst_seq_nexysvideo;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 8;
    localparam int unsigned STR  = 16;

    logic       clk = 1'b0;
    logic       rst_i, btn, srst, lock;
    logic       rst_sys_no, rst_active_o;
    logic [1:0] reset_cause_o;
    logic [7:0] rst_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rst_seq_nexysvideo #(
        .SyncStages    (SYNC),
        .DebounceCycles(DEB),
        .StretchCycles (STR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .btn_rst_ni   (btn),
        .srst_ni      (srst),
        .pll_locked_i (lock),
        .rst_sys_no   (rst_sys_no),
        .rst_active_o (rst_active_o),
        .reset_cause_o(reset_cause_o),
        .rst_count_o  (rst_count_o)
    );

    // src: 0 button, 1 srst, 2 pll lock
    typedef struct {
        string      name;
        int         src;
        int         len;
        int         exp_low;
        logic [1:0] exp_cause;
        logic [7:0] exp_cnt;
    } vec_t;

    typedef struct {
        string      name;
        int         low;
        logic [1:0] cause;
        logic [7:0] cnt;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_src(input int src, input logic v);
        case (src)
            0:       btn  = v;
            1:       srst = v;
            default: lock = v;
        endcase
    endtask

    // Drive a low pulse of len cycles and count cycles with reset asserted.
    task automatic run_pulse(input int src, input int len, input int window,
                             output int lows, output int bad_active);
        lows       = 0;
        bad_active = 0;
        for (int n = 0; n < window; n++) begin
            @(negedge clk);
            if (!rst_sys_no) lows++;
            if (rst_active_o == rst_sys_no) bad_active++;
            set_src(src, (n < len) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic apply_row(input vec_t v);
        int   lows, bad;
        exp_t e;
        sb.push_back('{v.name, v.exp_low, v.exp_cause, v.exp_cnt});
        run_pulse(v.src, v.len, 80, lows, bad);
        e = sb.pop_front();
        check({e.name, " low cycles"}, lows, e.low);
        check({e.name, " cause"}, int'(reset_cause_o), int'(e.cause));
        check({e.name, " count"}, int'(rst_count_o), int'(e.cnt));
        check({e.name, " active inverse"}, bad, 0);
    endtask

    // Hold rst_i, check reset values, then check release lands on edge 19.
    task automatic powerup(input string tag);
        int early;
        rst_i = 1'b1;
        btn   = 1'b1;
        srst  = 1'b1;
        lock  = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, " reset rst_sys_no"}, int'(rst_sys_no), 0);
        check({tag, " reset rst_active_o"}, int'(rst_active_o), 1);
        check({tag, " reset cause"}, int'(reset_cause_o), 0);
        check({tag, " reset count"}, int'(rst_count_o), 0);
        rst_i = 1'b0;
        early = 0;
        for (int k = 1; k <= int'(SYNC + 1 + STR); k++) begin
            @(posedge clk);
            #1;
            if (k < int'(SYNC + 1 + STR) && rst_sys_no) early++;
        end
        check({tag, " no release before edge 19"}, early, 0);
        check({tag, " released after edge 19"}, int'(rst_sys_no), 1);
        check({tag, " active after release"}, int'(rst_active_o), 0);
        check({tag, " cause after release"}, int'(reset_cause_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         lows, bad, bad_iter;
        logic [1:0] c10, c30;
        exp_t       e;

        vecs[0] = '{"btn glitch 5",   0, 5,  0,  2'b00, 8'd0};
        vecs[1] = '{"btn glitch 7",   0, 7,  0,  2'b00, 8'd0};
        vecs[2] = '{"btn press 8",    0, 8,  24, 2'b01, 8'd1};
        vecs[3] = '{"btn press 20",   0, 20, 36, 2'b01, 8'd2};
        vecs[4] = '{"srst pulse 3",   1, 3,  19, 2'b10, 8'd3};
        vecs[5] = '{"lock loss 1",    2, 1,  17, 2'b11, 8'd4};
        vecs[6] = '{"srst pulse 1",   1, 1,  17, 2'b10, 8'd5};
        vecs[7] = '{"lock loss 4",    2, 4,  20, 2'b11, 8'd6};

        powerup("por");

        for (int i = 0; i < 8; i++) apply_row(vecs[i]);

        // Lock and button drop together, then srst aborts STRETCH.
        sb.push_back('{"simultaneous", 43, 2'b10, 8'd7});
        lows = 0;
        c10  = 2'b00;
        c30  = 2'b00;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (!rst_sys_no) lows++;
            if (n == 10) c10 = reset_cause_o;
            if (n == 30) c30 = reset_cause_o;
            lock = (n < 10) ? 1'b0 : 1'b1;
            btn  = (n < 10) ? 1'b0 : 1'b1;
            srst = (n >= 24 && n < 27) ? 1'b0 : 1'b1;
        end
        e = sb.pop_front();
        check("simultaneous first cause", int'(c10), 3);
        check("simultaneous abort cause", int'(c30), int'(e.cause));
        check("simultaneous low cycles", lows, e.low);
        check("simultaneous count", int'(rst_count_o), int'(e.cnt));

        // Saturation: 260 more RUN->HOLD events.
        bad_iter = 0;
        for (int i = 0; i < 260; i++) begin
            run_pulse(1, 1, 24, lows, bad);
            if (lows != int'(STR + 1) || bad != 0) bad_iter++;
        end
        check("saturation per-event low cycles", bad_iter, 0);
        check("saturation count", int'(rst_count_o), 255);
        run_pulse(1, 1, 24, lows, bad);
        check("saturation holds", int'(rst_count_o), 255);

        // rst_i asserted while in STRETCH.
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n == 8) begin
                check("midop pre rst_sys_no", int'(rst_sys_no), 0);
                check("midop pre cause", int'(reset_cause_o), 2);
                check("midop pre count", int'(rst_count_o), 255);
                rst_i = 1'b1;
            end
            if (n == 9) begin
                check("midop rst_sys_no", int'(rst_sys_no), 0);
                check("midop rst_active_o", int'(rst_active_o), 1);
                check("midop cause", int'(reset_cause_o), 0);
                check("midop count", int'(rst_count_o), 0);
            end
            srst = (n < 1) ? 1'b0 : 1'b1;
        end

        powerup("re-por");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
